wrp_shff_ingress: RTL
=====================

Name: wrp_shff_ingress

Overview:
AIE-facing ingress stage of the shuffle wrapper. It accepts a 64-bit AXI4-Stream from the AIE array and buffers it in a 16-deep skid FIFO. It then drives the shuffle network's vld/dat interface, honouring a registered rdy that arrives late. It also tracks frame boundaries against FRAME_LEN and flags tlast misalignment. It is the producer side that feeds the shuffle network, which in turn feeds the per-port output FIFOs.

Parameters:
DEPTH_LOG2, 4, log2 of skid FIFO depth (16 entries).
FRAME_LEN, 1024, beats per frame; range 2..65535.
CNT_W, 16, width of the frame counter output.

Ports:
clk  in  1  clock
srst_i  in  1  synchronous active-high reset
axi_tvld  in  1  AIE stream valid
axi_tdat  in  64  AIE stream data
axi_tlast  in  1  AIE stream last (end of frame)
axi_trdy  out  1  ready to AIE, registered
rdy_i  in  1  shuffle-network ready, registered by consumer
vld_o  out  1  beat valid to shuffle network, registered
dat_o  out  64  beat data, registered
sof_o  out  1  qualifies vld_o: first beat of a frame
err_o  out  1  sticky tlast-misalignment flag
frm_cnt_o  out  CNT_W  frames fully emitted, wraps at 2^CNT_W

Behaviour:
- srst_i is registered once internally as srst. All state and outputs take reset values at the edge where srst=1, which is 2 edges after srst_i first sampled high.
- Reset values: axi_trdy=0, vld_o=0, dat_o=0, sof_o=0, err_o=0, frm_cnt_o=0; FIFO empty; beat counters 0.
- Reset mid-frame discards all buffered data. The next accepted beat is treated as beat 0.
- First cycle out of reset: axi_trdy rises 1 cycle after srst falls.
- Accept rule: a beat is pushed at an edge where axi_tvld & axi_trdy = 1.
- axi_trdy is registered as (occupancy after this edge's push/pop) < 2^DEPTH_LOG2 - 2. This one-cycle margin makes overflow impossible. Overflow is an assertion failure.
- Pop rule: pop at an edge when FIFO not empty & rdy_i = 1. At the same edge, vld_o<=1 and dat_o<=head. Otherwise vld_o<=0 and dat_o holds its value.
- The consumer sizes its almost-full margin for registered rdy, so popping on the sampled rdy_i is legal.
- Latency: a beat accepted at edge t can appear on vld_o/dat_o at edge t+2 when the FIFO was empty and rdy_i=1. Steady-state throughput is 1 beat/cycle.
- Simultaneous push and pop in one edge: occupancy is unchanged, including when the FIFO is at occupancy 1. Data ordering is strictly FIFO.
- Input beat counter in_cnt: 0..FRAME_LEN-1, increments on each push, wraps to 0.
  - If axi_tlast=1 and in_cnt != FRAME_LEN-1: err_o<=1 (sticky until reset) and in_cnt<=0 (resync).
  - If in_cnt=FRAME_LEN-1 and axi_tlast=0: err_o<=1 and in_cnt wraps to 0 normally.
- FIFO entries store {tdat, sof_bit, eof_bit}; sof_bit=(in_cnt==0) and eof_bit=(in_cnt==FRAME_LEN-1 or tlast).
- sof_o is registered alongside vld_o and equals the popped sof_bit; it is 0 when vld_o=0.
- frm_cnt_o increments when a popped beat has eof_bit=1, and wraps at 2^CNT_W.

Decomposition:
- Shared shuffle-wrapper package: constants for DAT_W=64 and FIFO entry width DAT_W+2; entry field positions SOF_BIT=64, EOF_BIT=65.
- One sub-module: wrp_shff_ingress_fifo, a synchronous distributed-RAM FIFO with 1-cycle read.
  - Ports: clk, srst, we, wd, re, rd, empty, count.
- Top level holds the trdy logic, beat counter, error flag and output registers.

Test Plan:
- Reset, then a 1024-beat frame with tlast on beat 1023 and rdy_i=1 -> vld_o 1024 cycles contiguous; sof_o only on the first; dat_o order matches; frm_cnt_o=1; err_o=0.
- Single beat (0xDEADBEEF_00000001) into empty FIFO, rdy_i=1 -> vld_o=1 with that data at edge t+2 exactly.
- rdy_i=0 held for 40 cycles with axi_tvld=1 continuously -> axi_trdy falls once occupancy hits 14; no beat lost; occupancy never exceeds 15; 14 or 15 beats drain in order after rdy_i=1.
- tlast asserted on beat 500 of FRAME_LEN=1024 -> err_o=1 from the next cycle and stays 1; the following beat carries sof_o=1 on output.
- srst_i pulsed for 1 cycle mid-frame with 8 beats buffered -> 2 edges later vld_o=0, FIFO empty, frm_cnt_o=0, err_o=0; next accepted beat emerges with sof_o=1.
- Random axi_tvld and rdy_i (50% each) over 10 frames -> scoreboard exact data match; frm_cnt_o=10; err_o=0.

Source files
------------

// File: rtl/wrp_shff_ingress_pkg.sv
// Shared shuffle-wrapper definitions: data width, FIFO entry layout and
// the helper that packs an ingress beat into a FIFO entry.
package wrp_shff_ingress_pkg;

    localparam int DAT_W   = 64;
    localparam int ENT_W   = DAT_W + 2;
    localparam int SOF_BIT = 64;
    localparam int EOF_BIT = 65;

    typedef logic [ENT_W-1:0] ent_t;

    function automatic ent_t pack_ent(input logic [DAT_W-1:0] dat,
                                      input logic             sof,
                                      input logic             eof);
        return {eof, sof, dat};
    endfunction

endpackage

// File: rtl/wrp_shff_ingress_fifo.sv
// Skid FIFO for the ingress stage: distributed-RAM storage plus a
// registered head stage, so an entry becomes poppable the cycle after it lands.
module wrp_shff_ingress_fifo
    import wrp_shff_ingress_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  we,
    input  ent_t                  wd,
    input  logic                  re,
    output ent_t                  rd,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    ent_t              mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  mem_cnt;
    logic              out_vld;
    logic              load;

    // Refill the head register whenever it is free or being popped this edge.
    assign load  = (mem_cnt != '0) && (!out_vld || re);
    assign empty = !out_vld;
    assign count = mem_cnt + CNT_W'(out_vld);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            rd <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            out_vld <= 1'b0;
        end else begin
            if (we) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({we, load})
                2'b10:   mem_cnt <= mem_cnt + CNT_W'(1);
                2'b01:   mem_cnt <= mem_cnt - CNT_W'(1);
                default: mem_cnt <= mem_cnt;
            endcase
            if (load) begin
                out_vld <= 1'b1;
            end else if (re) begin
                out_vld <= 1'b0;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (srst)
        !(we && !load && mem_cnt == CNT_FULL));

    a_no_underflow: assert property (@(posedge clk) disable iff (srst)
        !(re && !out_vld));

endmodule

// File: rtl/wrp_shff_ingress.sv
// AIE-facing ingress stage: buffers the AXI4-Stream in a skid FIFO, drives
// the shuffle network vld/dat interface and tracks frame alignment.
module wrp_shff_ingress
    import wrp_shff_ingress_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int FRAME_LEN  = 1024,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              srst_i,
    input  logic              axi_tvld,
    input  logic [DAT_W-1:0]  axi_tdat,
    input  logic              axi_tlast,
    output logic              axi_trdy,
    input  logic              rdy_i,
    output logic              vld_o,
    output logic [DAT_W-1:0]  dat_o,
    output logic              sof_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  frm_cnt_o
);

    localparam int OCC_W = DEPTH_LOG2 + 1;
    localparam int IN_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    // Two slots of headroom: trdy is registered, so one more beat can land
    // after the FIFO decides it is nearly full.
    localparam logic [OCC_W-1:0] TRDY_LIM  = OCC_W'((1 << DEPTH_LOG2) - 2);
    localparam logic [IN_W-1:0]  LAST_BEAT = IN_W'(FRAME_LEN - 1);

    logic              srst;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              last_beat;
    logic              sof_bit;
    logic              eof_bit;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_next;
    logic [IN_W-1:0]   in_cnt;
    ent_t              wr_ent;
    ent_t              head;

    always_ff @(posedge clk) begin
        srst <= srst_i;
    end

    assign push      = axi_tvld & axi_trdy;
    assign pop       = ~fifo_empty & rdy_i;
    assign last_beat = (in_cnt == LAST_BEAT);
    assign sof_bit   = (in_cnt == '0);
    assign eof_bit   = last_beat | axi_tlast;
    assign wr_ent    = pack_ent(axi_tdat, sof_bit, eof_bit);
    assign occ_next  = occ + OCC_W'(push) - OCC_W'(pop);

    wrp_shff_ingress_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .srst  (srst),
        .we    (push),
        .wd    (wr_ent),
        .re    (pop),
        .rd    (head),
        .empty (fifo_empty),
        .count (occ)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            axi_trdy  <= 1'b0;
            vld_o     <= 1'b0;
            dat_o     <= '0;
            sof_o     <= 1'b0;
            err_o     <= 1'b0;
            frm_cnt_o <= '0;
            in_cnt    <= '0;
        end else begin
            axi_trdy <= (occ_next < TRDY_LIM);
            vld_o    <= pop;
            sof_o    <= pop & head[SOF_BIT];
            if (pop) begin
                dat_o <= head[DAT_W-1:0];
                if (head[EOF_BIT]) begin
                    frm_cnt_o <= frm_cnt_o + CNT_W'(1);
                end
            end
            // Any tlast/beat-count disagreement is sticky; tlast also resyncs.
            if (push) begin
                in_cnt <= eof_bit ? '0 : in_cnt + IN_W'(1);
                if (axi_tlast != last_beat) begin
                    err_o <= 1'b1;
                end
            end
        end
    end

endmodule
